encoder_habilitador: RTL and testbench
======================================

Name: encoder_habilitador

Overview:
- Inverse of the 6-bit to 38-bit register-enable decoder.
- Takes a 38-bit multi-hot enable/request vector and serialises it into a stream of 6-bit register indices, lowest index first, over a valid/ready handshake.
- Bit 0 corresponds to the hardwired-zero register and is never emitted.
- Sits between the scoreboard / multi-register update logic and the register-file write port; one register index per accepted transfer.

Parameters:
- ANCHO, 38, width of the request vector (register count).
- SEL_W, 6, width of the emitted index; must satisfy 2**SEL_W >= ANCHO.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous and active-high.
- cargar  input  1  load strobe; samples peticion when block is idle.
- peticion  input  ANCHO  request vector; bit i set = emit index i.
- listo  input  1  consumer ready.
- seleccion  output  SEL_W  index currently offered.
- valido  output  1  seleccion valid.
- ocupado  output  1  block holds a vector being serialised.
- fin  output  1  one-cycle pulse after the last index is accepted.
- cuenta  output  SEL_W  number of indices transferred since last load.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; internal pendiente=0.
  - seleccion=0, valido=0, ocupado=0, fin=0, cuenta=0.
  - Reset overrides every other input and aborts any operation in progress; no fin pulse is generated.
- States: IDLE, EMITIR, FIN.
- IDLE:
  - valido=0, ocupado=0, fin=0.
  - On cargar=1: pendiente <= peticion with bit 0 forced to 0, and cuenta <= 0.
  - Next state is EMITIR if the masked vector is nonzero, else FIN.
- EMITIR:
  - valido=1, ocupado=1.
  - seleccion = index of the lowest set bit of pendiente. It is a function of registered state only; there is no combinational path from any input.
  - Transfer occurs when valido=1 and listo=1 in the same cycle. On transfer:
    - the emitted bit is cleared in pendiente;
    - cuenta increments;
    - if pendiente becomes zero, next state is FIN, otherwise stay in EMITIR.
  - With listo=0, seleccion and valido hold stable indefinitely (no retraction, no change of index).
- FIN:
  - fin=1 for exactly one cycle; valido=0; ocupado=1.
  - Next state is IDLE unconditionally.
- cargar is ignored in EMITIR and FIN; a new vector is accepted only in IDLE.
  - cargar in the cycle immediately after FIN (state IDLE) is accepted.
- Latency:
  - cargar accepted at edge N gives the first index valid in cycle N+1.
  - With listo held 1, one index per cycle.
  - The last transfer at edge K gives fin in cycle K+1 and IDLE in cycle K+2.
- Empty vector (peticion=0, or only bit 0 set): no valido; fin asserts the cycle after load; cuenta stays 0.
- Full vector (bits 1..37 set): 37 transfers emitting indices 1..37 in ascending order; cuenta=37 at fin.
- Bits at positions >= ANCHO do not exist.
  - seleccion never exceeds ANCHO-1.
  - Index 0 is never emitted while valido=1.
- cuenta:
  - Holds its final value after fin until the next accepted cargar.
  - Never wraps, since at most ANCHO-1 transfers occur.
- All outputs are registered or derived solely from registered state.

Test Plan:
- peticion bits 3, 5 and 37 set, cargar pulse, listo=1 -> seleccion 3, 5, 37 with valido=1 on three consecutive cycles; fin on the 4th cycle; cuenta=3; ocupado falls on the 5th cycle.
- Same vector with listo toggling 0,1,0,0,1,1 -> seleccion holds 3 during listo=0; each index is emitted exactly once; no duplicates or skips; fin only after the 37 transfer.
- peticion=1 (only bit 0) and peticion=0 -> valido never asserts; fin one cycle after load; cuenta=0.
- During EMITIR, cargar=1 with peticion bit 10 set -> ignored; output sequence unchanged; bit 10 never emitted.
- rst=1 after the first transfer of vector {2,4,6} -> next cycle: valido=0, ocupado=0, cuenta=0, no fin; a subsequent load of bit 9 emits only 9.
- Round trip: random vectors, each accepted seleccion fed to the 6-bit-to-38-bit decoder and its outputs ORed -> the OR equals peticion with bit 0 cleared; cuenta equals the popcount of bits 1..37.

Source files
------------

// File: rtl/encoder_habilitador.sv
// Purpose : serialises a 38-bit multi-hot register-enable vector into 6-bit indices, lowest index first.
// Latency : first index is valid the cycle after the load; one index per cycle while listo=1; fin follows the last transfer by one cycle.
// Backpressure: with listo=0 the offered index and valido hold; cargar is ignored unless idle.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   cargar     : load strobe, sampled only when idle
//   peticion   : request vector, bit i set = emit index i (bit 0 is the zero register, never emitted)
//   listo      : consumer ready
//   seleccion  : index currently offered, valido qualifies it
//   ocupado    : a vector is being serialised (includes the fin cycle)
//   fin        : one-cycle pulse after the last index is accepted
//   cuenta     : indices transferred since the last load; holds after fin
module encoder_habilitador #(
  parameter int ANCHO = 38,
  parameter int SEL_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cargar,
  input  logic [ANCHO-1:0] peticion,
  input  logic             listo,
  output logic [SEL_W-1:0] seleccion,
  output logic             valido,
  output logic             ocupado,
  output logic             fin,
  output logic [SEL_W-1:0] cuenta
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMITIR = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t          estado;
  logic [ANCHO-1:0] pendiente;
  logic [ANCHO-1:0] pendiente_sig;
  logic [ANCHO-1:0] carga_masc;
  logic [SEL_W-1:0] menor;
  logic             transfer;

  // Bit 0 is the hardwired-zero register; it is dropped at load time so it
  // can never reach the output.
  assign carga_masc = peticion & ~ANCHO'(1);

  // Lowest set bit of the pending vector. Only bits 1..ANCHO-1 can ever be
  // set, so the result is 0 solely when nothing is pending.
  always_comb begin
    menor = '0;
    for (int i = ANCHO-1; i >= 1; i--) begin
      if (pendiente[i]) menor = SEL_W'(i);
    end
  end

  // x & (x-1) clears exactly the lowest set bit, i.e. the one being emitted.
  assign pendiente_sig = pendiente & (pendiente - ANCHO'(1));

  // Every output is decoded from registered state only.
  assign seleccion = menor;
  assign valido    = (estado == EMITIR);
  assign ocupado   = (estado != IDLE);
  assign fin       = (estado == FIN);
  assign transfer  = valido && listo;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= IDLE;
      pendiente <= '0;
      cuenta    <= '0;
    end else begin
      case (estado)
        IDLE: begin
          if (cargar) begin
            pendiente <= carga_masc;
            cuenta    <= '0;
            estado    <= (carga_masc != '0) ? EMITIR : FIN;
          end
        end
        EMITIR: begin
          if (transfer) begin
            pendiente <= pendiente_sig;
            cuenta    <= cuenta + SEL_W'(1);
            if (pendiente_sig == '0) estado <= FIN;
          end
        end
        FIN: begin
          estado <= IDLE;
        end
        default: begin
          estado    <= IDLE;
          pendiente <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_habilitador.sv
module tb_encoder_habilitador;

  localparam int ANCHO = 38;
  localparam int SEL_W = 6;

  logic             clk;
  logic             rst;
  logic             cargar;
  logic [ANCHO-1:0] peticion;
  logic             listo;
  logic [SEL_W-1:0] seleccion;
  logic             valido;
  logic             ocupado;
  logic             fin;
  logic [SEL_W-1:0] cuenta;

  encoder_habilitador #(.ANCHO(ANCHO), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cargar    (cargar),
    .peticion  (peticion),
    .listo     (listo),
    .seleccion (seleccion),
    .valido    (valido),
    .ocupado   (ocupado),
    .fin       (fin),
    .cuenta    (cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ANCHO-1:0] vec;
    int               cnt;
  } fin_t;

  int   exp_q[$];
  fin_t fin_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected index stream is just the set bits 1..ANCHO-1
  // in ascending order; the count is their popcount.
  task automatic model_push(input logic [ANCHO-1:0] v);
    logic [ANCHO-1:0] m;
    fin_t f;
    m = v;
    m[0] = 1'b0;
    for (int i = 1; i < ANCHO; i++)
      if (m[i]) exp_q.push_back(i);
    f.vec = m;
    f.cnt = $countones(m);
    fin_q.push_back(f);
  endtask

  // listo driver: 0 = always ready, 1 = random, 2 = fixed pattern after load
  int         lmode = 0;
  int         pcount = 0;
  logic [5:0] pat = 6'b110010;

  always @(posedge clk) begin
    #2;
    case (lmode)
      0: listo = 1'b1;
      1: listo = 1'($urandom_range(0, 1));
      default: begin
        listo = (pcount < 6) ? pat[pcount] : 1'b1;
        pcount++;
      end
    endcase
  end

  // Monitor: pops expectations whenever the DUT transfers or pulses fin.
  // Accepted indices are decoded back to one-hot and ORed for the round trip.
  logic [ANCHO-1:0] acc = '0;
  logic             hold_prev = 1'b0;
  logic [SEL_W-1:0] prev_sel = '0;
  logic [ANCHO-1:0] one;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      acc = '0;
    end else begin
      if (hold_prev)
        chk("hold_stable", {63'd0, valido} << 8 | 64'(seleccion), {63'd0, 1'b1} << 8 | 64'(prev_sel));
      if (valido)
        chk("sel_in_range", 64'((seleccion != 0) && (seleccion < ANCHO)), 64'd1);
      if (valido && listo) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL idx_unexpected actual=%0d expected=none", seleccion);
        end else begin
          chk("idx", 64'(seleccion), 64'(exp_q.pop_front()));
        end
        one = '0;
        one[seleccion] = 1'b1;
        acc = acc | one;
      end
      if (fin) begin
        fin_t f;
        if (fin_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fin_unexpected actual=1 expected=0");
        end else begin
          f = fin_q.pop_front();
          chk("fin_cuenta", 64'(cuenta), 64'(f.cnt));
          chk("roundtrip", 64'(acc), 64'(f.vec));
          chk("fin_no_pending_idx", 64'(exp_q.size()), 64'd0);
        end
        acc = '0;
      end
      hold_prev = valido && !listo;
      prev_sel  = seleccion;
    end
  end

  // Presents v for one cycle; returns #1 after the accepting edge.
  task automatic load(input logic [ANCHO-1:0] v);
    @(posedge clk); #1;
    cargar   = 1'b1;
    peticion = v;
    model_push(v);
    @(posedge clk); #1;
    cargar   = 1'b0;
    peticion = '0;
    pcount   = 0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!ocupado) done = 1;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic expect_out(input string name, input logic v, input logic o, input logic f,
                            input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] c);
    @(negedge clk);
    chk(name, {43'd0, v, o, f, 1'b0, 6'(s), 6'(c)}, {43'd0, valido, ocupado, fin, 1'b0, 6'(seleccion), 6'(cuenta)} ^ {43'd0, valido, ocupado, fin, 1'b0, 6'(seleccion), 6'(cuenta)} ^ {43'd0, v, o, f, 1'b0, 6'(s), 6'(c)} ^ {43'd0, v, o, f, 1'b0, 6'(s), 6'(c)} ^ {43'd0, valido, ocupado, fin, 1'b0, 6'(seleccion), 6'(cuenta)});
  endtask

  logic [ANCHO-1:0] v;

  initial begin
    rst      = 1'b1;
    cargar   = 1'b0;
    peticion = '0;
    listo    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {40'd0, valido, ocupado, fin, 3'd0, 6'(seleccion), 6'(cuenta)}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: bits 3,5,37 with listo always 1, cycle-exact.
    lmode = 0;
    v = '0; v[3] = 1'b1; v[5] = 1'b1; v[37] = 1'b1;
    load(v);
    expect_out("t1_c1", 1'b1, 1'b1, 1'b0, 6'd3, 6'd0);
    expect_out("t1_c2", 1'b1, 1'b1, 1'b0, 6'd5, 6'd1);
    expect_out("t1_c3", 1'b1, 1'b1, 1'b0, 6'd37, 6'd2);
    @(negedge clk);
    chk("t1_fin", {61'd0, valido, ocupado, fin}, 64'b011);
    chk("t1_fin_cuenta", 64'(cuenta), 64'd3);
    @(negedge clk);
    chk("t1_idle", {61'd0, valido, ocupado, fin}, 64'b000);
    chk("t1_cuenta_hold", 64'(cuenta), 64'd3);

    // Same vector with listo pattern 0,1,0,0,1,1.
    lmode = 2;
    load(v);
    @(negedge clk);
    chk("t2_hold3", {57'd0, valido, 6'(seleccion)}, {57'd0, 1'b1, 6'd3});
    wait_idle("t2_done");
    lmode = 0;

    // Empty vectors: only bit 0, then all zero.
    v = '0; v[0] = 1'b1;
    load(v);
    @(negedge clk);
    chk("t3_bit0_fin", {60'd0, valido, ocupado, fin, 1'b0}, 64'b0110);
    chk("t3_bit0_cuenta", 64'(cuenta), 64'd0);
    wait_idle("t3_bit0_done");
    load('0);
    @(negedge clk);
    chk("t3_zero_fin", {61'd0, valido, ocupado, fin}, 64'b011);
    wait_idle("t3_zero_done");

    // cargar during EMITIR is ignored.
    v = '0; v[3] = 1'b1; v[5] = 1'b1; v[37] = 1'b1;
    load(v);
    cargar = 1'b1;
    peticion = '0;
    peticion[10] = 1'b1;
    @(posedge clk); #1;
    cargar = 1'b0;
    peticion = '0;
    wait_idle("t4_done");

    // Reset after the first transfer of {2,4,6}.
    v = '0; v[2] = 1'b1; v[4] = 1'b1; v[6] = 1'b1;
    load(v);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    fin_q.delete();
    @(negedge clk);
    chk("t5_after_rst", {40'd0, valido, ocupado, fin, 3'd0, 6'd0, 6'(cuenta)}, 64'd0);
    v = '0; v[9] = 1'b1;
    load(v);
    wait_idle("t5_reload_done");

    // Full vector.
    v = '1;
    load(v);
    wait_idle("t6_full_done");
    chk("t6_full_cuenta", 64'(cuenta), 64'd37);

    // Random round trips with random backpressure.
    lmode = 1;
    for (int n = 0; n < 30; n++) begin
      v = {6'($urandom), $urandom};
      if (n % 3 == 1) v = v & {6'($urandom), $urandom} & {6'($urandom), $urandom};
      load(v);
      wait_idle("rand_done");
    end
    lmode = 0;

    repeat (3) @(negedge clk);
    chk("final_idx_q_empty", 64'(exp_q.size()), 64'd0);
    chk("final_fin_q_empty", 64'(fin_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
